irq_ctrl_rv32: RTL and testbench

Parametrised machine-mode interrupt controller for the RV32 core: it owns the `mie` (0x304) and `mip` (0x344) CSRs for MSI/MTI/MEI plus `NUM_LOCAL` platform-local interrupts (cause 16+i). It also synchronises the raw interrupt lines, latches edge-type sources, and presents one registered, prioritised interrupt request to the trap logic. It replaces the fixed three-bit enable register.

---
 rtl/irq_ctrl_rv32_pkg.sv | 41 ++++
 rtl/irq_ctrl_rv32_sync.sv | 24 ++
 rtl/irq_ctrl_rv32.sv | 123 ++++++++++++
 tb/tb_irq_ctrl_rv32.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_rv32_pkg.sv
// Shared CSR addresses, op encodings, cause codes and CSR helper functions
// for the machine-mode interrupt controller.
package irq_pkg;

    localparam logic [11:0] CSR_MIE = 12'h304;
    localparam logic [11:0] CSR_MIP = 12'h344;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_WR   = 2'b01,
        CSR_OP_SET  = 2'b10,
        CSR_OP_CLR  = 2'b11
    } csr_op_e;

    localparam logic [4:0] CAUSE_MSI        = 5'd3;
    localparam logic [4:0] CAUSE_MTI        = 5'd7;
    localparam logic [4:0] CAUSE_MEI        = 5'd11;
    localparam logic [4:0] CAUSE_LOCAL_BASE = 5'd16;

    function automatic logic [31:0] mie_mask(input int unsigned num_local);
        logic [31:0] m;
        m = 32'h0000_0888;
        for (int i = 0; i < 16; i++)
            if (i < int'(num_local)) m[16+i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                              input logic [31:0] old,
                                              input logic [31:0] wdata);
        logic [31:0] r;
        case (op)
            CSR_OP_WR:  r = wdata;
            CSR_OP_SET: r = old | wdata;
            CSR_OP_CLR: r = old & ~wdata;
            default:    r = old;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/irq_ctrl_rv32_sync.sv
// Multi-flop synchroniser for asynchronous interrupt lines; also exposes the
// stage feeding the output so callers can detect edges without extra latency.
module irq_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] pre_o
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) chain_q <= '0;
        else         chain_q <= {chain_q[STAGES-2:0], d_i};
    end

    assign q_o   = chain_q[STAGES-1];
    assign pre_o = chain_q[STAGES-2];

endmodule

// File: rtl/irq_ctrl_rv32.sv
// Machine-mode interrupt controller: mie/mip CSRs, line synchronisation,
// edge latching of local sources and a registered prioritised request.
module irq_ctrl_rv32
    import irq_pkg::*;
#(
    parameter int unsigned          NUM_LOCAL   = 4,
    parameter logic [NUM_LOCAL-1:0] LOCAL_EDGE  = '0,
    parameter int unsigned          SYNC_STAGES = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [11:0]          csr_addr_in,
    input  logic                 csr_wr_en_in,
    input  logic [1:0]           csr_op_in,
    input  logic [31:0]          csr_wdata_in,
    output logic [31:0]          csr_rdata_out,
    input  logic                 mstatus_mie_in,
    input  logic                 sw_irq_in,
    input  logic                 timer_irq_in,
    input  logic                 ext_irq_in,
    input  logic [NUM_LOCAL-1:0] local_irq_in,
    input  logic                 irq_ack_in,
    output logic [31:0]          mie_reg_out,
    output logic [31:0]          mip_reg_out,
    output logic                 irq_req_out,
    output logic [4:0]           irq_cause_out
);

    localparam int unsigned NL       = 3 + NUM_LOCAL;
    localparam logic [31:0] MIE_MASK = mie_mask(NUM_LOCAL);

    logic [NL-1:0]        raw_lines, line_s, line_pre;
    logic [NUM_LOCAL-1:0] pend_q, pend_d, rise, clr;
    logic [31:0]          mie_q, mie_d, mip, elig;
    logic                 req_q, req_d;
    logic [4:0]           cause_q, cause_d;
    logic                 mie_hit, mip_clr_hit;
    logic                 unused_pre;

    assign raw_lines = {local_irq_in, ext_irq_in, timer_irq_in, sw_irq_in};

    irq_sync #(.WIDTH(NL), .STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (clk_in),
        .rst_ni (rst_in),
        .d_i    (raw_lines),
        .q_o    (line_s),
        .pre_o  (line_pre)
    );

    assign unused_pre = ^line_pre[2:0];

    // Highest local index wins, then MEI, MSI, MTI.
    function automatic logic [4:0] prio_cause(input logic [31:0] e);
        logic [4:0] c;
        c = '0;
        if (e[CAUSE_MTI]) c = CAUSE_MTI;
        if (e[CAUSE_MSI]) c = CAUSE_MSI;
        if (e[CAUSE_MEI]) c = CAUSE_MEI;
        for (int i = 0; i < int'(NUM_LOCAL); i++)
            if (e[16+i]) c = CAUSE_LOCAL_BASE + 5'(i);
        return c;
    endfunction

    always_comb begin
        mip                = '0;
        mip[CAUSE_MSI]     = line_s[0];
        mip[CAUSE_MTI]     = line_s[1];
        mip[CAUSE_MEI]     = line_s[2];
        for (int i = 0; i < int'(NUM_LOCAL); i++)
            mip[16+i] = LOCAL_EDGE[i] ? pend_q[i] : line_s[3+i];
    end

    assign mie_hit     = csr_wr_en_in && (csr_addr_in == CSR_MIE);
    assign mip_clr_hit = csr_wr_en_in && (csr_addr_in == CSR_MIP) &&
                         (csr_op_in == CSR_OP_WR || csr_op_in == CSR_OP_CLR);

    always_comb begin
        mie_d = mie_q;
        if (mie_hit) mie_d = csr_apply(csr_op_in, mie_q, csr_wdata_in) & MIE_MASK;
    end

    // Rise is seen one stage early so the pending bit lands with the level mirror.
    always_comb begin
        rise = line_pre[NL-1:3] & ~line_s[NL-1:3];
        for (int i = 0; i < int'(NUM_LOCAL); i++)
            clr[i] = (mip_clr_hit &&
                      ((csr_op_in == CSR_OP_WR)  ? !csr_wdata_in[16+i] : csr_wdata_in[16+i])) ||
                     (irq_ack_in && (cause_q == CAUSE_LOCAL_BASE + 5'(i)));
        pend_d = ((pend_q & ~clr) | rise) & LOCAL_EDGE;
    end

    always_comb begin
        elig    = mstatus_mie_in ? (mip & mie_q) : '0;
        req_d   = !irq_ack_in && (elig != '0);
        cause_d = (elig != '0) ? prio_cause(elig) : cause_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mie_q   <= '0;
            pend_q  <= '0;
            req_q   <= 1'b0;
            cause_q <= '0;
        end else begin
            mie_q   <= mie_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        csr_rdata_out = '0;
        if (csr_addr_in == CSR_MIE)      csr_rdata_out = mie_q;
        else if (csr_addr_in == CSR_MIP) csr_rdata_out = mip;
    end

    assign mie_reg_out   = mie_q;
    assign mip_reg_out   = mip;
    assign irq_req_out   = req_q;
    assign irq_cause_out = cause_q;

endmodule

// File: tb/tb_irq_ctrl_rv32.sv
// Bench for irq_ctrl_rv32: vector table, directed corner sequences and random
// traffic, all compared against a cycle-level reference model.
module tb_irq_ctrl_rv32;

    localparam int NL = 4;
    localparam int SS = 2;
    localparam logic [NL-1:0] EDGE  = 4'b0001;
    localparam logic [31:0]   MIE_W = 32'h000F_0888;
    localparam int ORDER [7] = '{19, 18, 17, 16, 11, 3, 7};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [11:0]   addr;
    logic          wr_en;
    logic [1:0]    op;
    logic [31:0]   wdata, rdata;
    logic          mst, sw, tm, ex, ack;
    logic [NL-1:0] loc;
    logic [31:0]   mie_o, mip_o;
    logic          req;
    logic [4:0]    cause;

    irq_ctrl_rv32 #(.NUM_LOCAL(NL), .LOCAL_EDGE(EDGE), .SYNC_STAGES(SS)) dut (
        .clk_in(clk), .rst_in(rst_n),
        .csr_addr_in(addr), .csr_wr_en_in(wr_en), .csr_op_in(op),
        .csr_wdata_in(wdata), .csr_rdata_out(rdata),
        .mstatus_mie_in(mst), .sw_irq_in(sw), .timer_irq_in(tm), .ext_irq_in(ex),
        .local_irq_in(loc), .irq_ack_in(ack),
        .mie_reg_out(mie_o), .mip_reg_out(mip_o),
        .irq_req_out(req), .irq_cause_out(cause)
    );

    int total = 0;
    int bad   = 0;

    // reference model: hist[0] is the newest line sample, hist[SS-1] the visible one
    logic [31:0]   m_mie;
    logic [NL-1:0] m_pend;
    logic          m_req;
    logic [4:0]    m_cause;
    logic [NL+2:0] hist [SS];
    logic [31:0]   last_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mie = '0; m_pend = '0; m_req = 1'b0; m_cause = '0;
        for (int k = 0; k < SS; k++) hist[k] = '0;
    endtask

    function automatic logic [31:0] model_mip();
        logic [31:0]   v;
        logic [NL+2:0] s;
        v = '0;
        s = hist[SS-1];
        v[3] = s[0]; v[7] = s[1]; v[11] = s[2];
        for (int i = 0; i < NL; i++) v[16+i] = EDGE[i] ? m_pend[i] : s[3+i];
        return v;
    endfunction

    function automatic logic [4:0] winner(input logic [31:0] e);
        for (int k = 0; k < 7; k++) if (e[ORDER[k]]) return 5'(ORDER[k]);
        return m_cause;
    endfunction

    // One clock: check the combinational read, advance the model, compare state.
    task automatic step();
        logic [31:0]   mip_now, nmie, elig, newv;
        logic [NL+2:0] olds, news;
        logic [NL-1:0] npend;
        logic          clr_i;
        @(negedge clk);
        mip_now = model_mip();
        last_rd = rdata;
        chk("rdata", rdata, (addr == 12'h304) ? m_mie : (addr == 12'h344) ? mip_now : 32'h0);
        nmie = m_mie;
        if (wr_en && addr == 12'h304)
            case (op)
                2'b01: nmie = wdata & MIE_W;
                2'b10: nmie = (m_mie | wdata) & MIE_W;
                2'b11: nmie = m_mie & ~wdata;
                default: ;
            endcase
        elig = mst ? (mip_now & m_mie) : 32'h0;
        newv = (op == 2'b01) ? wdata : (mip_now & ~wdata);
        olds = hist[SS-1];
        for (int k = SS-1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = {loc, ex, tm, sw};
        news = hist[SS-1];
        for (int i = 0; i < NL; i++) begin
            clr_i = (ack && m_cause == 5'(16+i)) ||
                    (wr_en && addr == 12'h344 && (op == 2'b01 || op == 2'b11) && !newv[16+i]);
            if (!EDGE[i])                  npend[i] = 1'b0;
            else if (news[3+i] && !olds[3+i]) npend[i] = 1'b1;
            else if (clr_i)                npend[i] = 1'b0;
            else                           npend[i] = m_pend[i];
        end
        m_cause = (elig != 0) ? winner(elig) : m_cause;
        m_req   = !ack && (elig != 0);
        m_mie   = nmie;
        m_pend  = npend;
        @(posedge clk); #1;
        chk("mie", mie_o, m_mie);
        chk("mip", mip_o, model_mip());
        chk("req", {31'b0, req}, {31'b0, m_req});
        chk("cause", {27'b0, cause}, {27'b0, m_cause});
    endtask

    task automatic csr(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d);
        wr_en = 1'b1; op = o; addr = a; wdata = d;
        step();
        wr_en = 1'b0; op = 2'b00; addr = 12'h304;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [31:0] exp_mie;
    } vec_t;
    vec_t vecs [11];

    initial begin
        vecs[0]  = '{2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0,         32'h000F_0888};
        vecs[1]  = '{2'b01, 12'h304, 32'h0,         32'h000F_0888, 32'h0};
        vecs[2]  = '{2'b10, 12'h304, 32'h0000_0080, 32'h0,         32'h0000_0080};
        vecs[3]  = '{2'b11, 12'h304, 32'h0000_0008, 32'h0000_0080, 32'h0000_0080};
        vecs[4]  = '{2'b10, 12'h304, 32'h0001_0008, 32'h0000_0080, 32'h0001_0088};
        vecs[5]  = '{2'b11, 12'h304, 32'hFFFF_FFFF, 32'h0001_0088, 32'h0};
        vecs[6]  = '{2'b01, 12'h305, 32'hFFFF_FFFF, 32'h0,         32'h0};
        vecs[7]  = '{2'b00, 12'h304, 32'hFFFF_FFFF, 32'h0,         32'h0};
        vecs[8]  = '{2'b01, 12'h304, 32'h0000_F0F0, 32'h0,         32'h0000_0080};
        vecs[9]  = '{2'b01, 12'h344, 32'hFFFF_FFFF, 32'h0,         32'h0000_0080};
        vecs[10] = '{2'b01, 12'h300, 32'h0,         32'h0,         32'h0000_0080};

        rst_n = 1'b0; addr = 12'h304; wr_en = 1'b0; op = 2'b00; wdata = '0;
        mst = 1'b0; sw = 1'b0; tm = 1'b0; ex = 1'b0; loc = '0; ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk); #1;
        chk("rst_mie", mie_o, 32'h0);
        chk("rst_mip", mip_o, 32'h0);
        chk("rst_req", {31'b0, req}, 32'h0);
        chk("rst_cause", {27'b0, cause}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 11; v++) begin
            csr(vecs[v].op, vecs[v].addr, vecs[v].wdata);
            chk($sformatf("vec%0d_rd", v), last_rd, vecs[v].exp_rd);
            chk($sformatf("vec%0d_mie", v), mie_o, vecs[v].exp_mie);
        end

        // timer latency, mie = 0x80 from the table
        mst = 1'b1; tm = 1'b1;
        step(); chk("tmr_mip_n", mip_o, 32'h0);
        step(); chk("tmr_mip_n1", mip_o, 32'h80); chk("tmr_req_n1", {31'b0, req}, 32'h0);
        step(); chk("tmr_req_n2", {31'b0, req}, 32'h1); chk("tmr_cause", {27'b0, cause}, 32'd7);
        csr(2'b11, 12'h344, 32'h0000_0888); chk("mip_clr_ro", mip_o, 32'h80);
        csr(2'b10, 12'h344, 32'h0000_0888); chk("mip_set_ro", mip_o, 32'h80);
        mst = 1'b0;
        step(); step(); chk("tmr_gated", {31'b0, req}, 32'h0);
        tm = 1'b0; mst = 1'b1;

        // priority and acknowledge
        csr(2'b01, 12'h304, 32'hFFFF_FFFF);
        sw = 1'b1; ex = 1'b1; loc[2] = 1'b1;
        repeat (3) step();
        chk("prio_cause18", {27'b0, cause}, 32'd18); chk("prio_req", {31'b0, req}, 32'h1);
        ack = 1'b1; loc[2] = 1'b0;
        step(); chk("ack_req_low", {31'b0, req}, 32'h0);
        ack = 1'b0;
        step(); step(); chk("prio_cause11", {27'b0, cause}, 32'd11);
        ack = 1'b1; step(); chk("ack2_low", {31'b0, req}, 32'h0);
        ack = 1'b0; step(); chk("level_rereq", {31'b0, req}, 32'h1);
        sw = 1'b0; ex = 1'b0;

        // edge-latched local 0
        csr(2'b01, 12'h304, 32'h0001_0000);
        repeat (3) step();
        loc[0] = 1'b1; step(); loc[0] = 1'b0;
        repeat (3) step();
        chk("edge_held", mip_o, 32'h0001_0000); chk("edge_cause", {27'b0, cause}, 32'd16);
        ack = 1'b1; step(); ack = 1'b0;
        chk("edge_ack_clr", mip_o, 32'h0);
        loc[0] = 1'b1; step();
        loc[0] = 1'b0; ack = 1'b1; step(); ack = 1'b0;
        chk("edge_set_wins", mip_o, 32'h0001_0000);
        step();
        csr(2'b11, 12'h344, 32'h0001_0000); chk("edge_csr_clr", mip_o, 32'h0);

        // asynchronous reset mid-request
        csr(2'b01, 12'h304, 32'h80); tm = 1'b1;
        repeat (3) step();
        chk("pre_rst_req", {31'b0, req}, 32'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_req", {31'b0, req}, 32'h0);
        chk("arst_mie", mie_o, 32'h0);
        tm = 1'b0;
        do_reset();

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0, 3: addr = 12'h304;
                1:    addr = 12'h344;
                default: addr = 12'($urandom);
            endcase
            wr_en = ($urandom_range(0, 2) == 0);
            op    = 2'($urandom_range(0, 3));
            wdata = $urandom;
            if ($urandom_range(0, 1) == 0) wdata = wdata & 32'h000F_0888;
            mst = ($urandom_range(0, 4) != 0);
            ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) sw = ~sw;
            if ($urandom_range(0, 5) == 0) tm = ~tm;
            if ($urandom_range(0, 5) == 0) ex = ~ex;
            for (int i = 0; i < NL; i++) if ($urandom_range(0, 4) == 0) loc[i] = ~loc[i];
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
